// File: rtl/wjbot_riscv.sv
// Shared types and constants for the multicycle RV32I core: opcodes, controller
// state encodings, ALUOp codes and ALU control codes.
package wjbot_riscv;

    // Opcodes the multicycle controller recognises
    typedef enum logic [6:0] {
        OP_R_TYPE     = 7'b0110011,
        OP_I_TYPE_ALU = 7'b0010011,
        OP_LW         = 7'b0000011,
        OP_SW         = 7'b0100011,
        OP_BEQ        = 7'b1100011,
        OP_JAL        = 7'b1101111
    } opcodetype_t;

    // Controller states; the encodings are visible on StateDbg
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_EXECI    = 4'd8,
        ST_JAL      = 4'd9,
        ST_BEQ      = 4'd10
    } statetype_t;

    // ALUOp: what the controller asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU control codes driven to the datapath
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    // Immediate format depends only on the opcode
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LW:         imm = 2'b00;
            OP_I_TYPE_ALU: imm = 2'b00;
            OP_SW:         imm = 2'b01;
            OP_BEQ:        imm = 2'b10;
            OP_JAL:        imm = 2'b11;
            default:       imm = 2'b00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to an ALU control code.
module alu_decoder
    import wjbot_riscv::*;
(
    input  logic       op_5,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);

    // Select the ALU operation; only R-type with funct7[5] set turns 000 into sub
    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op_5 && funct7_5) begin
                            alu_control = ALUC_SUB;
                        end else begin
                            alu_control = ALUC_ADD;
                        end
                    end
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared datapath. ALU operation comes from alu_decoder.
module multicycle_controller
    import wjbot_riscv::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [3:0] StateDbg
);

    statetype_t state_r;
    statetype_t state_nxt_s;

    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;

    // State register; reset returns to FETCH at the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-state output decode; unlisted outputs stay at their 0 defaults
    always_comb begin
        state_nxt_s  = ST_FETCH;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALUOP_ADD;
        case (state_r)
            ST_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                pc_update_s  = 1'b1;
                state_nxt_s  = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op)
                    OP_LW, OP_SW:  state_nxt_s = ST_MEMADR;
                    OP_R_TYPE:     state_nxt_s = ST_EXECR;
                    OP_I_TYPE_ALU: state_nxt_s = ST_EXECI;
                    OP_BEQ:        state_nxt_s = ST_BEQ;
                    OP_JAL:        state_nxt_s = ST_JAL;
                    // Unknown opcodes retire as a NOP without touching state
                    default:       state_nxt_s = ST_FETCH;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op == OP_LW) begin
                    state_nxt_s = ST_MEMREAD;
                end else begin
                    state_nxt_s = ST_MEMWRITE;
                end
            end
            ST_MEMREAD: begin
                adr_src_s   = 1'b1;
                state_nxt_s = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                state_nxt_s  = ST_FETCH;
            end
            ST_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALUOP_FUNCT;
                state_nxt_s = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write_s = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            ST_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALUOP_FUNCT;
                state_nxt_s = ST_ALUWB;
            end
            ST_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                state_nxt_s = ST_ALUWB;
            end
            ST_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALUOP_SUB;
                branch_s    = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            // Unreachable encodings: all enables low, recover to FETCH
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .op_5        (op[5]),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_op      (alu_op_s),
        .alu_control (ALUControl)
    );

    // Enables are held low while reset is asserted so nothing commits mid-abort
    assign PCWrite   = ~reset & (pc_update_s | (branch_s & Zero));
    assign IRWrite   = ~reset & ir_write_s;
    assign MemWrite  = ~reset & mem_write_s;
    assign RegWrite  = ~reset & reg_write_s;
    assign AdrSrc    = adr_src_s;
    assign ResultSrc = result_src_s;
    assign ALUSrcA   = alu_src_a_s;
    assign ALUSrcB   = alu_src_b_s;
    assign ImmSrc    = imm_src_of(op);
    assign StateDbg  = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through
// its state sequence and checks state, datapath selects and enables every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [3:0] StateDbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .StateDbg   (StateDbg)
    );

    always #5 clk = ~clk;

    // {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite}
    logic [9:0] ctrl_obs;
    assign ctrl_obs = {AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite};

    // Hand-tabulated state-decoded controls
    function automatic logic [9:0] exp_ctrl(input logic [3:0] s);
        logic [9:0] v;
        case (s)
            4'd0:    v = 10'b0_0_1_10_00_10_0;
            4'd1:    v = 10'b0_0_0_00_01_01_0;
            4'd2:    v = 10'b0_0_0_00_10_01_0;
            4'd3:    v = 10'b1_0_0_00_00_00_0;
            4'd4:    v = 10'b0_0_0_01_00_00_1;
            4'd5:    v = 10'b1_1_0_00_00_00_0;
            4'd6:    v = 10'b0_0_0_00_10_00_0;
            4'd7:    v = 10'b0_0_0_00_00_00_1;
            4'd8:    v = 10'b0_0_0_00_10_01_0;
            4'd9:    v = 10'b0_0_0_00_01_10_0;
            4'd10:   v = 10'b0_0_0_00_10_00_0;
            default: v = 10'b0;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Check one cycle of a sequence, then advance to the next falling edge
    task automatic step(input string tag, input logic [3:0] s, input logic pcw,
                        input logic [2:0] aluc);
        #1;
        chk({tag, "/state"}, 16'(StateDbg), 16'(s));
        chk({tag, "/ctrl"}, 16'(ctrl_obs), 16'(exp_ctrl(s)));
        chk({tag, "/pcw"}, 16'(PCWrite), 16'(pcw));
        chk({tag, "/aluc"}, 16'(ALUControl), 16'(aluc));
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        op       = 7'b0000000;
        funct3   = 3'b000;
        funct7_5 = 1'b0;
        Zero     = 1'b0;

        // Reset held three cycles: no enables
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_en", 16'({PCWrite, IRWrite, MemWrite, RegWrite}), 16'h0);
        end
        chk("rst_state", 16'(StateDbg), 16'h0);

        // Release: FETCH, then DECODE of an illegal opcode returns to FETCH
        reset = 1'b0;
        step("rel0", 4'd0, 1'b1, 3'b000);
        step("rel1", 4'd1, 1'b0, 3'b000);

        // lw
        op = 7'b0000011;
        #1 chk("imm_lw", 16'(ImmSrc), 16'h0);
        step("lw0", 4'd0, 1'b1, 3'b000);
        step("lw1", 4'd1, 1'b0, 3'b000);
        step("lw2", 4'd2, 1'b0, 3'b000);
        step("lw3", 4'd3, 1'b0, 3'b000);
        step("lw4", 4'd4, 1'b0, 3'b000);

        // sw
        op = 7'b0100011;
        #1 chk("imm_sw", 16'(ImmSrc), 16'h1);
        step("sw0", 4'd0, 1'b1, 3'b000);
        step("sw1", 4'd1, 1'b0, 3'b000);
        step("sw2", 4'd2, 1'b0, 3'b000);
        step("sw5", 4'd5, 1'b0, 3'b000);

        // sub
        op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        #1 chk("imm_r", 16'(ImmSrc), 16'h0);
        step("sub0", 4'd0, 1'b1, 3'b000);
        step("sub1", 4'd1, 1'b0, 3'b000);
        step("sub6", 4'd6, 1'b0, 3'b001);
        step("sub7", 4'd7, 1'b0, 3'b000);

        // or / and / slt in EXECR
        funct3 = 3'b110; funct7_5 = 1'b0;
        step("or0", 4'd0, 1'b1, 3'b000);
        step("or1", 4'd1, 1'b0, 3'b000);
        step("or6", 4'd6, 1'b0, 3'b011);
        step("or7", 4'd7, 1'b0, 3'b000);
        funct3 = 3'b111;
        step("and0", 4'd0, 1'b1, 3'b000);
        step("and1", 4'd1, 1'b0, 3'b000);
        step("and6", 4'd6, 1'b0, 3'b010);
        step("and7", 4'd7, 1'b0, 3'b000);
        funct3 = 3'b010;
        step("slt0", 4'd0, 1'b1, 3'b000);
        step("slt1", 4'd1, 1'b0, 3'b000);
        step("slt6", 4'd6, 1'b0, 3'b101);
        step("slt7", 4'd7, 1'b0, 3'b000);

        // addi with funct7_5 set still adds
        op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
        #1 chk("imm_i", 16'(ImmSrc), 16'h0);
        step("addi0", 4'd0, 1'b1, 3'b000);
        step("addi1", 4'd1, 1'b0, 3'b000);
        step("addi8", 4'd8, 1'b0, 3'b000);
        step("addi7", 4'd7, 1'b0, 3'b000);

        // beq taken: Zero high throughout, PCWrite only from FETCH and BEQ
        op = 7'b1100011; funct7_5 = 1'b0; Zero = 1'b1;
        #1 chk("imm_beq", 16'(ImmSrc), 16'h2);
        step("beqt0", 4'd0, 1'b1, 3'b000);
        step("beqt1", 4'd1, 1'b0, 3'b000);
        step("beqt10", 4'd10, 1'b1, 3'b001);

        // beq not taken
        Zero = 1'b0;
        step("beqn0", 4'd0, 1'b1, 3'b000);
        step("beqn1", 4'd1, 1'b0, 3'b000);
        step("beqn10", 4'd10, 1'b0, 3'b001);

        // jal
        op = 7'b1101111;
        #1 chk("imm_jal", 16'(ImmSrc), 16'h3);
        step("jal0", 4'd0, 1'b1, 3'b000);
        step("jal1", 4'd1, 1'b0, 3'b000);
        step("jal9", 4'd9, 1'b1, 3'b000);
        step("jal7", 4'd7, 1'b0, 3'b000);

        // Illegal opcode behaves as a NOP
        op = 7'b1111111;
        #1 chk("imm_ill", 16'(ImmSrc), 16'h0);
        step("ill0", 4'd0, 1'b1, 3'b000);
        step("ill1", 4'd1, 1'b0, 3'b000);

        // Reset asserted in MEMREAD aborts the lw
        op = 7'b0000011;
        step("ab0", 4'd0, 1'b1, 3'b000);
        step("ab1", 4'd1, 1'b0, 3'b000);
        step("ab2", 4'd2, 1'b0, 3'b000);
        #1 chk("ab3_state", 16'(StateDbg), 16'h3);
        reset = 1'b1;
        #1 chk("ab3_en", 16'({PCWrite, IRWrite, MemWrite, RegWrite}), 16'h0);
        @(negedge clk);
        #1 chk("ab_rst_state", 16'(StateDbg), 16'h0);
        chk("ab_rst_en", 16'({PCWrite, IRWrite, MemWrite, RegWrite}), 16'h0);
        reset = 1'b0;
        step("ab_rel0", 4'd0, 1'b1, 3'b000);
        step("ab_rel1", 4'd1, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
